// File: rtl/pc_sequencer.sv
// Program-counter sequencer with Start/Done run control and a saturating RUN-cycle counter.
// All outputs registered, one-edge latency; Stall freezes PC/state in RUN (no ready handshake).
module pc_sequencer #(
  parameter int          PC_W       = 10,
  parameter int unsigned START_ADDR = 0,
  parameter int          CNT_W      = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Stall,
  input  logic             Halt,
  input  logic             BranchRel,
  input  logic             BranchAbs,
  input  logic [PC_W-1:0]  Target,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Running,
  output logic             Done,
  output logic [CNT_W-1:0] CycleCount
);

  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             running_q, running_d;
  logic             done_q, done_d;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= START_PC;
      cnt_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (Start) state_d = ST_ARMED;
      ST_ARMED: if (!Start) state_d = ST_RUN;
      ST_RUN:   if (!Stall && Halt) state_d = ST_DONE;
      ST_DONE:  if (Start) state_d = ST_ARMED;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          pc_d  = START_PC;
          cnt_d = '0;
        end
      end
      ST_ARMED: pc_d = START_PC;
      ST_RUN: begin
        // Counts stall and halting edges too; sticks at all-ones.
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        if (!Stall && !Halt) begin
          if (BranchAbs)      pc_d = Target;
          else if (BranchRel) pc_d = pc_q + Target;
          else                pc_d = pc_q + PC_W'(1);
        end
      end
      default: pc_d = pc_q;
    endcase
  end

  assign ProgCtr    = pc_q;
  assign Running    = running_q;
  assign Done       = done_q;
  assign CycleCount = cnt_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the 3BC basic processor; sits directly downstream of the branch/address lookup table and upstream of instruction memory. It holds the 10-bit program counter and advances it by one each cycle. When decode signals a taken branch, it instead applies the lookup-table output, either as a signed relative offset or as an absolute target. It also runs the Start/Done run-control handshake with the testbench and counts execution cycles for benchmarking.

## Interface
- PC_W, 10, program-counter width; equals the lookup-table output width
- START_ADDR, 0, PC value loaded on reset and on each Start
- CNT_W, 16, cycle-counter width
- Clk  input  1  single clock; all state updates on rising edge
- Reset  input  1  synchronous, active-low reset; sampled on rising edge of Clk
- Start  input  1  run-control request from testbench; level-sensitive
- Stall  input  1  freeze PC and control state this cycle
- Halt  input  1  decode: current instruction is halt
- BranchRel  input  1  decode: taken relative branch, PC += Target
- BranchAbs  input  1  decode: taken absolute jump, PC = Target
- Target  input  PC_W  lookup-table output (two's complement when used as relative offset)
- ProgCtr  output  PC_W  current instruction address, registered
- Running  output  1  high in RUN state, registered
- Done  output  1  high in DONE state, registered
- CycleCount  output  CNT_W  cycles spent in RUN since last Start, saturating

## Operation
- States: IDLE, ARMED, RUN, DONE (2-bit encoded).
- Reset (Reset==0 at edge), from any state, mid-run included:
  - state=IDLE, ProgCtr=START_ADDR, Running=0, Done=0, CycleCount=0.
- IDLE:
  - Start=1 -> ARMED; ProgCtr=START_ADDR; CycleCount=0.
  - Start=0 -> stay in IDLE.
- ARMED:
  - Start=1 -> stay; ProgCtr held at START_ADDR.
  - Start=0 -> RUN. The first instruction fetched is START_ADDR.
- RUN: per-edge priority Stall > Halt > BranchAbs > BranchRel > increment.
  - Stall=1: ProgCtr, state hold; CycleCount still increments.
  - Halt=1: -> DONE; ProgCtr holds (points at halt instruction).
  - BranchAbs=1: ProgCtr=Target.
  - BranchRel=1: ProgCtr=(ProgCtr+Target) mod 2^PC_W, Target sign-extended; no overflow flag.
  - Otherwise: ProgCtr=(ProgCtr+1) mod 2^PC_W (1023 wraps to 0).
- DONE:
  - ProgCtr and CycleCount frozen.
  - Start=1 -> ARMED (restart, same as IDLE exit).
- Start asserted during RUN is ignored; run-control is only re-armed from IDLE/DONE.
- CycleCount increments on every edge while state==RUN, including the halting edge and stall edges; saturates at 2^CNT_W-1.
- Control inputs (Stall, Halt, Branch*, Target) ignored outside RUN.

## Timing
- All outputs registered; change only on rising Clk edge; no combinational input-to-output path.
- Branch latency: Target/BranchRel sampled at edge N, new ProgCtr visible after edge N; zero bubble cycles.
- Done rises on the edge after Halt is sampled; Running falls on the same edge.
- Start→Running:
  - Start=1 sampled -> ARMED (1 edge).
  - Start=0 sampled -> Running=1 on the following edge.
- Reset has priority over every input on the same edge.

## Test plan
- Reset: hold Reset=0 two cycles with random inputs -> ProgCtr=0, Running=0, Done=0, CycleCount=0; release, Start=0 -> stays IDLE.
- Start handshake: Start=1 three cycles then 0 -> ProgCtr=0 throughout, Running=1 one edge after Start falls; five free cycles -> ProgCtr=5, CycleCount=5.
- Relative branch with negative offset: at ProgCtr=420, BranchRel=1, Target=10'h267 (-409) -> ProgCtr=11. At ProgCtr=1020, Target=10 -> ProgCtr=6 (wrap).
- Priority: at ProgCtr=100, BranchAbs=1, BranchRel=1, Target=300 -> ProgCtr=300. Stall=1 with Halt=1 -> no change, state RUN. Halt=1 with BranchAbs=1 -> DONE, ProgCtr=300 held.
- Halt/restart: Halt at ProgCtr=7 -> Done=1, ProgCtr=7, CycleCount frozen. Start pulse -> ProgCtr=0, CycleCount=0, Done=0; run resumes.
- Saturation and mid-run reset: run with CNT_W forced to 4 for 20 cycles -> CycleCount=15. Reset=0 mid-RUN -> IDLE, all outputs at reset values next edge.
